// File: rtl/barrel_shifter_pipelined_pkg.sv
// rtl/barrel_shifter_pipelined_pkg.sv - shared mode and direction types for the pipelined barrel shifter
package barrel_shifter_pipelined_pkg;

    typedef enum logic [1:0] {
        ROTATE     = 2'b00,
        LOGICAL    = 2'b01,
        ARITHMETIC = 2'b10,
        RESERVED   = 2'b11
    } shift_mode_t;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } shift_direction_t;

endpackage

// File: rtl/barrel_shifter_stage.sv
// rtl/barrel_shifter_stage.sv - one conditional shift level with its register slice and handshake
module barrel_shifter_stage
    import barrel_shifter_pipelined_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHIFT = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_amount,
    input  logic                     in_direction,
    input  logic [1:0]               in_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(WIDTH)-1:0] out_amount,
    output logic                     out_direction,
    output logic [1:0]               out_mode
);

    // Amount bit consumed by this level: SHIFT is 2^BIT.
    localparam int BIT = $clog2(SHIFT);

    logic                     valid_q;
    logic [WIDTH-1:0]         data_q;
    logic [WIDTH-1:0]         data_d;
    logic [WIDTH-1:0]         shifted;
    logic [$clog2(WIDTH)-1:0] amount_q;
    logic                     direction_q;
    logic [1:0]               mode_q;
    logic                     advance;

    // The slot is free when empty or when the downstream takes its contents this cycle.
    assign advance  = !valid_q || out_ready;
    assign in_ready = advance;

    // Shift by SHIFT in the requested direction/mode; bypass when this amount bit is clear.
    always_comb begin
        shifted = in_data;
        if (in_direction == RIGHT) begin
            case (shift_mode_t'(in_mode))
                LOGICAL:    shifted = in_data >> SHIFT;
                ARITHMETIC: shifted = $signed(in_data) >>> SHIFT;
                default:    shifted = {in_data[SHIFT-1:0], in_data[WIDTH-1:SHIFT]};
            endcase
        end else begin
            case (shift_mode_t'(in_mode))
                LOGICAL, ARITHMETIC: shifted = in_data << SHIFT;
                default:             shifted = {in_data[WIDTH-SHIFT-1:0], in_data[WIDTH-1:WIDTH-SHIFT]};
            endcase
        end
        data_d = in_amount[BIT] ? shifted : in_data;
    end

    // Register slice; payload loads only when a valid transfer moves in.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q     <= 1'b0;
            data_q      <= '0;
            amount_q    <= '0;
            direction_q <= 1'b0;
            mode_q      <= 2'b00;
        end else if (advance) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q      <= data_d;
                amount_q    <= in_amount;
                direction_q <= in_direction;
                mode_q      <= in_mode;
            end
        end
    end

    assign out_valid     = valid_q;
    assign out_data      = data_q;
    assign out_amount    = amount_q;
    assign out_direction = direction_q;
    assign out_mode      = mode_q;

endmodule

// File: rtl/barrel_shifter_pipelined.sv
// rtl/barrel_shifter_pipelined.sv - pipelined rotate/shift unit with valid/ready backpressure
module barrel_shifter_pipelined
    import barrel_shifter_pipelined_pkg::*;
#(
    parameter int  WIDTH      = 8,
    localparam int WIDTH_LOG2 = $clog2(WIDTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [WIDTH_LOG2-1:0] in_amount,
    input  logic                  in_direction,
    input  logic [1:0]            in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data
);

    // Index k feeds stage k; index WIDTH_LOG2 feeds the output register.
    logic                  valid_w     [0:WIDTH_LOG2];
    logic [WIDTH-1:0]      data_w      [0:WIDTH_LOG2];
    logic [WIDTH_LOG2-1:0] amount_w    [0:WIDTH_LOG2];
    logic                  direction_w [0:WIDTH_LOG2];
    logic [1:0]            mode_w      [0:WIDTH_LOG2];

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_advance;
    logic             unused_tail;

    assign valid_w[0]     = in_valid;
    assign data_w[0]      = in_data;
    assign amount_w[0]    = in_amount;
    assign direction_w[0] = in_direction;
    assign mode_w[0]      = in_mode;

    // Control fields are fully consumed by the last shift level.
    assign unused_tail = ^{amount_w[WIDTH_LOG2], direction_w[WIDTH_LOG2], mode_w[WIDTH_LOG2]};

    assign out_advance = !out_valid_q || out_ready;

    // Levels in LSB-first order; the ready chain is combinational back to the input.
    for (genvar k = 0; k < WIDTH_LOG2; k++) begin : g_stage
        logic stage_in_ready;
        logic stage_out_ready;

        if (k == WIDTH_LOG2 - 1) begin : g_tail
            assign stage_out_ready = out_advance;
        end else begin : g_link
            assign stage_out_ready = g_stage[k+1].stage_in_ready;
        end

        barrel_shifter_stage #(
            .WIDTH(WIDTH),
            .SHIFT(1 << k)
        ) u_stage (
            .clock        (clock),
            .reset        (reset),
            .in_valid     (valid_w[k]),
            .in_ready     (stage_in_ready),
            .in_data      (data_w[k]),
            .in_amount    (amount_w[k]),
            .in_direction (direction_w[k]),
            .in_mode      (mode_w[k]),
            .out_valid    (valid_w[k+1]),
            .out_ready    (stage_out_ready),
            .out_data     (data_w[k+1]),
            .out_amount   (amount_w[k+1]),
            .out_direction(direction_w[k+1]),
            .out_mode     (mode_w[k+1])
        );
    end

    assign in_ready = g_stage[0].stage_in_ready;

    // Output register holds the result steady while the downstream stalls.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (out_advance) begin
            out_valid_q <= valid_w[WIDTH_LOG2];
            if (valid_w[WIDTH_LOG2]) begin
                out_data_q <= data_w[WIDTH_LOG2];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_barrel_shifter_pipelined.sv
// tb/tb_barrel_shifter_pipelined.sv - scoreboard bench for the pipelined barrel shifter
module tb_barrel_shifter_pipelined;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic [2:0] in_amount = 3'd0;
    logic       in_direction = 1'b0;
    logic [1:0] in_mode = 2'b00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    bit         rand_ready = 1'b0;
    bit         hold_pending = 1'b0;
    logic [7:0] hold_data = 8'h00;

    barrel_shifter_pipelined #(.WIDTH(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_amount   (in_amount),
        .in_direction(in_direction),
        .in_mode     (in_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] ref_shift(input logic [7:0] d, input int amt, input logic dir,
                                             input logic [1:0] mode);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            int src;
            src = dir ? i + amt : i - amt;
            if (src >= 0 && src < 8) r[i] = d[src];
            else if (mode == 2'b01) r[i] = 1'b0;
            else if (mode == 2'b10) r[i] = dir ? d[7] : 1'b0;
            else r[i] = d[(src + 8) % 8];
        end
        return r;
    endfunction

    // Hold inputs until accepted; push the expected result at the accepting edge.
    task automatic send(input logic [7:0] d, input logic [2:0] a, input logic dir,
                        input logic [1:0] m, input logic [7:0] e);
        int waited;
        waited = 0;
        in_valid = 1'b1;
        in_data = d;
        in_amount = a;
        in_direction = dir;
        in_mode = m;
        @(negedge clock);
        while (!in_ready && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        if (in_ready) exp_q.push_back(e);
        else check_eq("send_accept", in_ready, 1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clock);
            n++;
        end
        check_eq("drain", exp_q.size(), 0);
        @(posedge clock);
        #1;
    endtask

    task automatic send_ref(input logic [7:0] d, input logic [2:0] a, input logic dir, input logic [1:0] m);
        send(d, a, dir, m, (a == 3'd0) ? d : ref_shift(d, int'(a), dir, m));
    endtask

    // Output monitor: scoreboard pops on transfer, stability check across stalled cycles.
    always @(negedge clock) begin
        if (reset) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check_eq("hold_valid", out_valid, 1);
                check_eq("hold_data", out_data, hold_data);
            end
            hold_pending = out_valid && !out_ready;
            hold_data = out_data;
            if (out_valid && out_ready) begin
                check_eq("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check_eq("result", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1);
    end

    initial begin
        logic [7:0] bp_data[6];
        logic [2:0] bp_amt[6];
        logic       bp_dir[6];
        logic [1:0] bp_mode[6];
        int         idx;
        int         acc;
        int         first;
        int         last;
        int         cnt;

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_in_ready", in_ready, 1);
        @(posedge clock);
        #1;

        send(8'b10011001, 3'd3, 1'b0, 2'b00, 8'b11001100);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check_eq("latency", out_valid, (i == 3) ? 32'd1 : 32'd0);
        end
        @(posedge clock);
        #1;
        wait_drain();

        send(8'b10011001, 3'd1, 1'b1, 2'b00, 8'b11001100);
        send(8'b10011001, 3'd2, 1'b1, 2'b01, 8'b00100110);
        send(8'b10011001, 3'd2, 1'b1, 2'b10, 8'b11100110);
        send(8'b10011001, 3'd4, 1'b0, 2'b01, 8'b10010000);
        first = -1;
        last = -1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (out_valid) begin
                if (first < 0) first = i;
                last = i;
                cnt++;
            end
        end
        check_eq("mix_count", cnt, 4);
        check_eq("mix_contiguous", last - first, 3);
        @(posedge clock);
        #1;
        wait_drain();

        for (int i = 0; i < 6; i++) begin
            bp_data[i] = 8'($urandom);
            bp_amt[i] = 3'($urandom_range(0, 7));
            bp_dir[i] = 1'($urandom_range(0, 1));
            bp_mode[i] = 2'($urandom_range(0, 3));
        end
        out_ready = 1'b0;
        idx = 0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = (idx < 6);
            if (idx < 6) begin
                in_data = bp_data[idx];
                in_amount = bp_amt[idx];
                in_direction = bp_dir[idx];
                in_mode = bp_mode[idx];
            end
            @(negedge clock);
            if (in_valid && in_ready) begin
                exp_q.push_back((bp_amt[idx] == 3'd0) ? bp_data[idx]
                                : ref_shift(bp_data[idx], int'(bp_amt[idx]), bp_dir[idx], bp_mode[idx]));
                idx++;
                acc++;
            end
            @(posedge clock);
            #1;
        end
        check_eq("bp_accepted", acc, 4);
        @(negedge clock);
        check_eq("bp_in_ready", in_ready, 0);
        check_eq("bp_out_valid", out_valid, 1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (idx < 6) begin
            send_ref(bp_data[idx], bp_amt[idx], bp_dir[idx], bp_mode[idx]);
            idx++;
        end
        wait_drain();

        for (int a = 0; a < 8; a++) begin
            for (int dr = 0; dr < 2; dr++) begin
                for (int m = 0; m < 4; m++) begin
                    send_ref(8'($urandom), 3'(a), 1'(dr), 2'(m));
                end
            end
        end
        wait_drain();

        send_ref(8'h81, 3'd1, 1'b0, 2'b00);
        send_ref(8'h42, 3'd2, 1'b1, 2'b10);
        send_ref(8'hC3, 3'd5, 1'b1, 2'b11);
        reset = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hA5;
        in_amount = 3'd1;
        exp_q.delete();
        @(posedge clock);
        @(negedge clock);
        check_eq("rst_flight_valid", out_valid, 0);
        check_eq("rst_flight_data", out_data, 0);
        check_eq("rst_flight_ready", in_ready, 1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        in_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (out_valid) cnt++;
        end
        check_eq("rst_no_stale", cnt, 0);
        @(posedge clock);
        #1;

        rand_ready = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clock);
                #1;
            end
            send_ref(8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                     2'($urandom_range(0, 3)));
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
